// File: rtl/rf_write_queue.sv
// Purpose : in-order write-back queue feeding the register file's single write port.
// Latency : a write accepted at edge N is presented on rf_* during cycle N+1 (no pass-through).
// Backpres: wr_ready = !full; drain_hold stalls the rf port and the queue fills behind it.
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   wr_valid/wr_ready/wr_reg/wr_data  write-back request handshake (wr_reg==0 accepted, dropped)
//   drain_hold                     suppress draining this cycle
//   rf_writeEn/rf_writeReg/rf_writeData  register file write port (zeros when idle)
//   lookup_reg1/2, hit1/2, hit_data1/2   bypass lookup of pending writes
//   count, empty, full             occupancy status
//
// Optional feature: define RF_WQ_BYPASS_EN to enable the bypass lookup; otherwise the
// hit outputs are tied to zero and the lookup inputs are ignored.

module rf_write_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [4:0]       wr_reg,
    input  logic [31:0]      wr_data,
    output logic             wr_ready,
    input  logic             drain_hold,
    output logic             rf_writeEn,
    output logic [4:0]       rf_writeReg,
    output logic [31:0]      rf_writeData,
    input  logic [4:0]       lookup_reg1,
    input  logic [4:0]       lookup_reg2,
    output logic             hit1,
    output logic             hit2,
    output logic [31:0]      hit_data1,
    output logic [31:0]      hit_data2,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full
);

    logic [4:0]       reg_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   cnt;
    logic             push;
    logic             pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == (PTR_W+1)'(DEPTH));
    assign wr_ready = !full;
    assign count    = cnt;

    // Writes to r0 complete the handshake but never occupy an entry.
    assign push = wr_valid && wr_ready && (wr_reg != 5'd0);
    assign pop  = rf_writeEn;

    assign rf_writeEn   = !empty && !drain_hold;
    assign rf_writeReg  = rf_writeEn ? reg_mem[rd_ptr]  : 5'd0;
    assign rf_writeData = rf_writeEn ? data_mem[rd_ptr] : 32'd0;

    // Storage is deliberately left out of reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr]  <= wr_reg;
            data_mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef RF_WQ_BYPASS_EN
    logic [PTR_W-1:0] scan_idx;

    // Walk from oldest to youngest so the last match seen is the youngest write.
    // The head is included even while it drains; the same-cycle push is not.
    always_comb begin
        hit1      = 1'b0;
        hit2      = 1'b0;
        hit_data1 = 32'd0;
        hit_data2 = 32'd0;
        scan_idx  = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = rd_ptr + PTR_W'(i);
            if ((PTR_W+1)'(i) < cnt) begin
                if (lookup_reg1 != 5'd0 && reg_mem[scan_idx] == lookup_reg1) begin
                    hit1      = 1'b1;
                    hit_data1 = data_mem[scan_idx];
                end
                if (lookup_reg2 != 5'd0 && reg_mem[scan_idx] == lookup_reg2) begin
                    hit2      = 1'b1;
                    hit_data2 = data_mem[scan_idx];
                end
            end
        end
    end
`else
    logic unused_lookup;

    assign unused_lookup = ^{lookup_reg1, lookup_reg2};
    assign hit1      = 1'b0;
    assign hit2      = 1'b0;
    assign hit_data1 = 32'd0;
    assign hit_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// Scoreboard bench for rf_write_queue: the stimulus process pushes every accepted
// non-r0 write into an expected queue; the negedge monitor pops it whenever the DUT
// drives the register file port and checks status, order and bypass results.

module tb_rf_write_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic [4:0]       wr_reg;
    logic [31:0]      wr_data;
    logic             wr_ready;
    logic             drain_hold;
    logic             rf_writeEn;
    logic [4:0]       rf_writeReg;
    logic [31:0]      rf_writeData;
    logic [4:0]       lookup_reg1;
    logic [4:0]       lookup_reg2;
    logic             hit1;
    logic             hit2;
    logic [31:0]      hit_data1;
    logic [31:0]      hit_data2;
    logic [PTR_W:0]   count;
    logic             empty;
    logic             full;

    ent_t exp_q[$];
    logic pend;
    ent_t pend_e;
    int   n_cmp;
    int   n_err;

    rf_write_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_reg(wr_reg), .wr_data(wr_data), .wr_ready(wr_ready),
        .drain_hold(drain_hold),
        .rf_writeEn(rf_writeEn), .rf_writeReg(rf_writeReg), .rf_writeData(rf_writeData),
        .lookup_reg1(lookup_reg1), .lookup_reg2(lookup_reg2),
        .hit1(hit1), .hit2(hit2), .hit_data1(hit_data1), .hit_data2(hit_data2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the DUT against the pending-write list once per cycle.
    always @(negedge clk) begin
        logic        e_en;
        logic        eh1, eh2;
        logic [31:0] ed1, ed2;
        ent_t        head;
        e_en = (exp_q.size() > 0) && !drain_hold;
        eh1 = 1'b0; eh2 = 1'b0; ed1 = 32'd0; ed2 = 32'd0;
`ifdef RF_WQ_BYPASS_EN
        foreach (exp_q[i]) begin
            if (lookup_reg1 != 5'd0 && exp_q[i].r == lookup_reg1) begin eh1 = 1'b1; ed1 = exp_q[i].d; end
            if (lookup_reg2 != 5'd0 && exp_q[i].r == lookup_reg2) begin eh2 = 1'b1; ed2 = exp_q[i].d; end
        end
`endif
        chk("count",    32'(count),    32'(exp_q.size()));
        chk("empty",    32'(empty),    32'(exp_q.size() == 0));
        chk("full",     32'(full),     32'(exp_q.size() == DEPTH));
        chk("wr_ready", 32'(wr_ready), 32'(exp_q.size() < DEPTH));
        chk("hit1",     32'(hit1),     32'(eh1));
        chk("hit2",     32'(hit2),     32'(eh2));
        chk("hit_data1", hit_data1, ed1);
        chk("hit_data2", hit_data2, ed2);
        chk("rf_writeEn", 32'(rf_writeEn), 32'(e_en));
        if (rf_writeEn && exp_q.size() > 0) begin
            head = exp_q.pop_front();
            chk("rf_writeReg",  32'(rf_writeReg), 32'(head.r));
            chk("rf_writeData", rf_writeData,     head.d);
        end else if (!rf_writeEn) begin
            chk("rf_writeReg_idle",  32'(rf_writeReg), 32'd0);
            chk("rf_writeData_idle", rf_writeData,     32'd0);
        end
    end

    // One clock of stimulus. Acceptance follows the model occupancy at the start of the
    // cycle, so a pop in the same cycle does not free a slot for a push.
    task automatic cycle(input logic v, input logic [4:0] r, input logic [31:0] d,
                         input logic hold, input logic [4:0] l1, input logic [4:0] l2,
                         output logic acc);
        @(posedge clk);
        #1;
        if (pend) begin
            exp_q.push_back(pend_e);
            pend = 1'b0;
        end
        wr_valid    = v;
        wr_reg      = r;
        wr_data     = d;
        drain_hold  = hold;
        lookup_reg1 = l1;
        lookup_reg2 = l2;
        acc = v && (exp_q.size() < DEPTH);
        if (acc && r != 5'd0) begin
            pend   = 1'b1;
            pend_e = '{r: r, d: d};
        end
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, a);
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        if (pend) begin
            exp_q.push_back(pend_e);
            pend = 1'b0;
        end
        wr_valid   = 1'b0;
        drain_hold = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_count",      32'(count),      32'd0);
        chk("rst_empty",      32'(empty),      32'd1);
        chk("rst_rf_writeEn", 32'(rf_writeEn), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic        acc;
        logic        cv;
        logic [4:0]  cr;
        logic [31:0] cd;
        n_cmp = 0; n_err = 0; pend = 1'b0;
        rst = 1'b1; wr_valid = 1'b0; wr_reg = 5'd0; wr_data = 32'd0;
        drain_hold = 1'b0; lookup_reg1 = 5'd0; lookup_reg2 = 5'd0;
        #1;
        chk("init_count",    32'(count),      32'd0);
        chk("init_empty",    32'(empty),      32'd1);
        chk("init_full",     32'(full),       32'd0);
        chk("init_wr_ready", 32'(wr_ready),   32'd1);
        chk("init_rf_en",    32'(rf_writeEn), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single write then drain.
        cycle(1'b1, 5'd5, 32'h1111_1111, 1'b0, 5'd5, 5'd0, acc);
        idle(3);

        // Fill under hold, stall a fifth write, then release.
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 5'(i), 32'hA000_0000 + 32'(i), 1'b1, 5'(i), 5'd3, acc);
        cycle(1'b1, 5'd6, 32'h6666_6666, 1'b1, 5'd2, 5'd6, acc);
        acc = 1'b0;
        for (int i = 0; i < 6 && !acc; i++)
            cycle(1'b1, 5'd6, 32'h6666_6666, 1'b0, 5'd4, 5'd6, acc);
        chk("r6_eventually_accepted", 32'(acc), 32'd1);
        idle(8);

        // r0 write: handshake completes, nothing queued.
        cycle(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, acc);
        idle(3);

        // Bypass: youngest of two pending writes to the same register.
        cycle(1'b1, 5'd7, 32'h0000_000A, 1'b1, 5'd7, 5'd8, acc);
        cycle(1'b1, 5'd7, 32'h0000_000B, 1'b1, 5'd7, 5'd8, acc);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd8, acc);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 5'd8, acc);
        idle(3);

        // Push and pop in the same cycle with two entries queued.
        cycle(1'b1, 5'd9,  32'h9999_0001, 1'b1, 5'd9, 5'd10, acc);
        cycle(1'b1, 5'd10, 32'h9999_0002, 1'b1, 5'd9, 5'd10, acc);
        cycle(1'b1, 5'd11, 32'h9999_0003, 1'b0, 5'd11, 5'd10, acc);
        cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 5'd9, acc);
        idle(5);

        // Reset with three entries queued and the drain port free.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'(12 + i), 32'hC000_0000 + 32'(i), 1'b1, 5'd12, 5'd14, acc);
        reset_pulse();
        idle(4);

        // Random traffic; a refused request is held until accepted.
        cv = 1'b0; cr = 5'd0; cd = 32'd0; acc = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if (!(cv && !acc)) begin
                cv = ($urandom_range(2, 0) != 0);
                cr = 5'($urandom_range(31, 0));
                cd = $urandom;
            end
            cycle(cv, cr, cd, ($urandom_range(3, 0) == 0),
                  5'($urandom_range(31, 0)), 5'($urandom_range(31, 0)), acc);
        end
        idle(2 * DEPTH + 4);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
